// File: rtl/npu_layer_sequencer_if.sv
// Handshake and ALU-facing bus of the NPU layer sequencer.
// NPU_SEQ_STALL_EN adds the stall_i request line.
interface npu_layer_sequencer_if;
    logic       start_i;
    logic       abort_i;
`ifdef NPU_SEQ_STALL_EN
    logic       stall_i;
`endif
    logic [7:0] alu_o;
    logic [4:0] w_reg_addr_npu_o;
    logic [3:0] result_sel_o;
    logic [2:0] layer_o;
    logic       busy_o;
    logic       done_o;

    modport master (
`ifdef NPU_SEQ_STALL_EN
        input  stall_i,
`endif
        input  start_i, abort_i,
        output alu_o, w_reg_addr_npu_o, result_sel_o, layer_o, busy_o, done_o
    );

    modport slave (
`ifdef NPU_SEQ_STALL_EN
        output stall_i,
`endif
        output start_i, abort_i,
        input  alu_o, w_reg_addr_npu_o, result_sel_o, layer_o, busy_o, done_o
    );
endinterface

// File: rtl/npu_layer_sequencer.sv
// Issues the LeNet layer opcodes C1..C5, a drain slot and the LRMOVE result transfers
// to the NPU ALU. Optional stall support is enabled with NPU_SEQ_STALL_EN.
`ifndef C1
`define C1     8'h11
`endif
`ifndef S2
`define S2     8'h12
`endif
`ifndef C3
`define C3     8'h13
`endif
`ifndef S4
`define S4     8'h14
`endif
`ifndef C5
`define C5     8'h15
`endif
`ifndef LRMOVE
`define LRMOVE 8'h20
`endif

module npu_layer_sequencer #(
    parameter int unsigned LAYER_HOLD   = 2,
    parameter int unsigned RESULT_BYTES = 10,
    parameter logic [4:0]  REG_BASE     = 5'd0,
    parameter logic [7:0]  IDLE_OP      = 8'h00
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    npu_layer_sequencer_if.master         seq
);
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_C1    = 4'd1,
        ST_S2    = 4'd2,
        ST_C3    = 4'd3,
        ST_S4    = 4'd4,
        ST_C5    = 4'd5,
        ST_DRAIN = 4'd6,
        ST_MOVE  = 4'd7,
        ST_DONE  = 4'd8
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(LAYER_HOLD - 1);
    localparam logic [3:0] BYTE_LAST = 4'(RESULT_BYTES - 1);

    state_t     state_r, state_s;
    logic [3:0] hold_cnt_r, hold_cnt_s;
    logic [3:0] byte_cnt_r, byte_cnt_s;
    logic       stall_s, abort_take_s, freeze_out_s;

    logic [7:0] alu_r, alu_s;
    logic [4:0] wreg_r, wreg_s;
    logic [3:0] sel_r, sel_s;
    logic [2:0] layer_r, layer_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;

`ifdef NPU_SEQ_STALL_EN
    assign stall_s = seq.stall_i;
`else
    assign stall_s = 1'b0;
`endif

    assign abort_take_s = seq.abort_i && (state_r != ST_IDLE);
    assign freeze_out_s = stall_s && !abort_take_s;

    // Next state and counters; abort beats stall, stall freezes everything.
    always_comb begin
        state_s    = state_r;
        hold_cnt_s = hold_cnt_r;
        byte_cnt_s = byte_cnt_r;
        if (abort_take_s) begin
            state_s    = ST_IDLE;
            hold_cnt_s = 4'd0;
            byte_cnt_s = 4'd0;
        end else if (stall_s) begin
            state_s    = state_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    hold_cnt_s = 4'd0;
                    byte_cnt_s = 4'd0;
                    if (seq.start_i && !seq.abort_i) begin
                        state_s = ST_C1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_C1, ST_S2, ST_C3, ST_S4, ST_C5: begin
                    // Enum codes are consecutive, so C5 + 1 lands on DRAIN.
                    if (hold_cnt_r == HOLD_LAST) begin
                        hold_cnt_s = 4'd0;
                        state_s    = state_t'(state_r + 4'd1);
                    end else begin
                        hold_cnt_s = hold_cnt_r + 4'd1;
                    end
                end
                ST_DRAIN: begin
                    state_s    = ST_MOVE;
                    byte_cnt_s = 4'd0;
                end
                ST_MOVE: begin
                    if (byte_cnt_r == BYTE_LAST) begin
                        state_s    = ST_DONE;
                        byte_cnt_s = 4'd0;
                    end else begin
                        byte_cnt_s = byte_cnt_r + 4'd1;
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s    = ST_IDLE;
                    hold_cnt_s = 4'd0;
                    byte_cnt_s = 4'd0;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so every output is a plain register.
    always_comb begin
        alu_s   = IDLE_OP;
        sel_s   = 4'd0;
        wreg_s  = 5'd0;
        layer_s = 3'd0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        if (freeze_out_s) begin
            alu_s   = IDLE_OP;
            sel_s   = sel_r;
            wreg_s  = wreg_r;
            layer_s = layer_r;
            busy_s  = busy_r;
            done_s  = done_r;
        end else begin
            case (state_s)
                ST_C1:    begin alu_s = `C1; layer_s = 3'd1; busy_s = 1'b1; end
                ST_S2:    begin alu_s = `S2; layer_s = 3'd2; busy_s = 1'b1; end
                ST_C3:    begin alu_s = `C3; layer_s = 3'd3; busy_s = 1'b1; end
                ST_S4:    begin alu_s = `S4; layer_s = 3'd4; busy_s = 1'b1; end
                ST_C5:    begin alu_s = `C5; layer_s = 3'd5; busy_s = 1'b1; end
                ST_DRAIN: begin layer_s = 3'd6; busy_s = 1'b1; end
                ST_MOVE: begin
                    alu_s   = `LRMOVE;
                    sel_s   = byte_cnt_s;
                    wreg_s  = REG_BASE + {1'b0, byte_cnt_s};
                    layer_s = 3'd7;
                    busy_s  = 1'b1;
                end
                ST_DONE:  begin done_s = 1'b1; end
                default:  begin alu_s = IDLE_OP; end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= 4'd0;
            byte_cnt_r <= 4'd0;
        end else begin
            state_r    <= state_s;
            hold_cnt_r <= hold_cnt_s;
            byte_cnt_r <= byte_cnt_s;
        end
    end

    // Output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alu_r   <= IDLE_OP;
            sel_r   <= 4'd0;
            wreg_r  <= 5'd0;
            layer_r <= 3'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            alu_r   <= alu_s;
            sel_r   <= sel_s;
            wreg_r  <= wreg_s;
            layer_r <= layer_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign seq.alu_o            = alu_r;
    assign seq.result_sel_o     = sel_r;
    assign seq.w_reg_addr_npu_o = wreg_r;
    assign seq.layer_o          = layer_r;
    assign seq.busy_o           = busy_r;
    assign seq.done_o           = done_r;
endmodule
